// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register-initialisation sequencer.
package sccb_pkg;

   typedef struct packed {
      logic [7:0] reg_addr;
      logic [7:0] val;
   } sccb_entry_t;

   localparam logic [15:0] SCCB_END     = 16'hFFFF;
   localparam logic [7:0]  SCCB_DLY_REG = 8'hFE;
   localparam logic [7:0]  SCCB_OV_ID   = 8'h42;

   // Entry i sits at bits [16*i +: 16]: soft reset, 10-unit settle, then clock prescaler.
   localparam int SCCB_MAX_DEPTH = 256;
   localparam logic [SCCB_MAX_DEPTH*16-1:0] SCCB_DEFAULT_TABLE =
      {{(SCCB_MAX_DEPTH*16-48){1'b1}}, 48'h1101_FE0A_1280};

   typedef enum logic [2:0] {
      PWR_WAIT,
      FETCH,
      DECODE,
      ISSUE,
      WAIT_ACK,
      DELAY,
      NEXT,
      DONE
   } sccb_state_t;

endpackage

// File: rtl/sccb_init_rom.sv
// Synchronous-read register table with one cycle of read latency.
module sccb_init_rom
   import sccb_pkg::*;
#(
   parameter int                  DEPTH = 256,
   parameter int                  AW    = $clog2(DEPTH),
   parameter logic [DEPTH*16-1:0] INIT  = '1
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   output sccb_entry_t   data
);

   sccb_entry_t mem [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_mem
      assign mem[i] = INIT[i*16 +: 16];
   end

   // NOTE: table read register carries no reset; the sequencer only looks at it after a FETCH cycle.
   always_ff @(posedge clk) begin
      data <= mem[addr];
   end

endmodule

// File: rtl/sccb_init_seq.sv
// Camera register-initialisation sequencer: walks a {reg, val} table and issues one
// SCCB write per entry, with delay entries, end marker, per-write timeout and re-run.
module sccb_init_seq
   import sccb_pkg::*;
#(
   parameter logic [7:0] DEVICE_ID         = SCCB_OV_ID,
   parameter int         PWR_WAIT_CYCLES   = 24000,
   parameter int         DELAY_UNIT_CYCLES = 24000,
   parameter int         TIMEOUT_CYCLES    = 65535,
   parameter int         ROM_DEPTH         = 256,
   parameter logic [ROM_DEPTH*16-1:0] ROM_INIT = SCCB_DEFAULT_TABLE[ROM_DEPTH*16-1:0],
   localparam int        IDX_W             = $clog2(ROM_DEPTH)
) (
   input  logic             XCLK,
   input  logic             RST,
   input  logic             rerun,
   input  logic             sccb_done,
   output logic             sccb_start,
   output logic             sccb_rw,
   output logic [7:0]       addr_id,
   output logic [7:0]       addr_reg,
   output logic [7:0]       data_out,
   output logic             init_busy,
   output logic             init_done,
   output logic             init_err,
   output logic [IDX_W-1:0] entry_idx
);

   localparam logic [31:0]      PWR_CNT  = 32'(PWR_WAIT_CYCLES);
   localparam logic [31:0]      DLY_UNIT = 32'(DELAY_UNIT_CYCLES);
   localparam logic [31:0]      TO_CNT   = 32'(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_DEPTH - 1);

   sccb_state_t state, state_next;
   sccb_entry_t rom_q;
   logic [31:0] cnt;
   logic        cnt_expired, is_end, is_dly, is_last, done_hold;

   sccb_init_rom #(
      .DEPTH (ROM_DEPTH),
      .AW    (IDX_W),
      .INIT  (ROM_INIT)
   ) u_rom (
      .clk  (XCLK),
      .addr (entry_idx),
      .data (rom_q)
   );

   assign sccb_rw     = 1'b0;
   assign addr_id     = DEVICE_ID;
   // One counter serves power-up wait, delay entries and the ack timeout; a load of N spans N cycles.
   assign cnt_expired = (cnt <= 32'd1);
   assign is_end      = (rom_q == SCCB_END);
   assign is_dly      = (rom_q.reg_addr == SCCB_DLY_REG);
   assign is_last     = (entry_idx == LAST_IDX);
   assign done_hold   = (state == DONE) && !rerun;

   // NOTE: registers update with <= so every flop samples values from before the edge.
   always_ff @(posedge XCLK or posedge RST) begin
      if (RST) state <= PWR_WAIT;
      else     state <= state_next;
   end

   // NOTE: state_next is defaulted first so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      case (state)
         PWR_WAIT: if (cnt_expired) state_next = FETCH;
         FETCH:    state_next = DECODE;
         DECODE: begin
            if (is_end)      state_next = DONE;
            else if (is_dly) state_next = DELAY;
            else             state_next = ISSUE;
         end
         ISSUE:    state_next = WAIT_ACK;
         WAIT_ACK: begin
            if (sccb_done)        state_next = NEXT;
            else if (cnt_expired) state_next = DONE;
         end
         DELAY:    if (cnt_expired) state_next = NEXT;
         NEXT:     state_next = is_last ? DONE : FETCH;
         DONE:     if (rerun) state_next = FETCH;
         default:  state_next = PWR_WAIT;
      endcase
   end

   always_ff @(posedge XCLK or posedge RST) begin
      if (RST) begin
         cnt        <= PWR_CNT;
         entry_idx  <= '0;
         addr_reg   <= '0;
         data_out   <= '0;
         init_err   <= 1'b0;
         sccb_start <= 1'b0;
         init_busy  <= 1'b1;
         init_done  <= 1'b0;
      end else begin
         sccb_start <= (state == ISSUE);
         init_busy  <= !done_hold;
         init_done  <= done_hold && !init_err;
         case (state)
            PWR_WAIT, DELAY: if (cnt != 32'd0) cnt <= cnt - 32'd1;
            DECODE: begin
               cnt <= 32'(rom_q.val) * DLY_UNIT;
               if (!is_end && !is_dly) begin
                  addr_reg <= rom_q.reg_addr;
                  data_out <= rom_q.val;
               end
            end
            // The timeout window opens on the cycle sccb_start is visible.
            ISSUE: cnt <= TO_CNT;
            WAIT_ACK: begin
               if (cnt != 32'd0) cnt <= cnt - 32'd1;
               if (!sccb_done && cnt_expired) init_err <= 1'b1;
            end
            NEXT: if (!is_last) entry_idx <= entry_idx + IDX_W'(1);
            DONE: begin
               if (rerun) begin
                  init_err  <= 1'b0;
                  entry_idx <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sccb_init_seq.sv
// Directed bench: four sequencer instances (basic, delay, timeout, full table) with a 10-cycle ack model.
module tb_sccb_init_seq;

   localparam int ACK_DLY = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] rst        = 4'hF;
   logic [3:0] rerun      = 4'h0;
   logic [3:0] stray      = 4'h0;
   logic [3:0] model_done = 4'h0;
   logic [3:0] ack_en     = 4'b1011;

   wire [3:0]      done_in;
   wire [3:0]      start_v, rw_v, busy_v, idone_v, err_v;
   wire [3:0][7:0] id_v, areg_v, dout_v;
   wire [3:0][1:0] idx_v;

   assign done_in = model_done | stray;

   sccb_init_seq #(.PWR_WAIT_CYCLES(4), .DELAY_UNIT_CYCLES(5), .TIMEOUT_CYCLES(40), .ROM_DEPTH(4),
                   .ROM_INIT(64'hFFFF_FFFF_1101_1280)) u_a (
      .XCLK(clk), .RST(rst[0]), .rerun(rerun[0]), .sccb_done(done_in[0]),
      .sccb_start(start_v[0]), .sccb_rw(rw_v[0]), .addr_id(id_v[0]), .addr_reg(areg_v[0]),
      .data_out(dout_v[0]), .init_busy(busy_v[0]), .init_done(idone_v[0]), .init_err(err_v[0]),
      .entry_idx(idx_v[0]));

   sccb_init_seq #(.PWR_WAIT_CYCLES(4), .DELAY_UNIT_CYCLES(5), .TIMEOUT_CYCLES(40), .ROM_DEPTH(4),
                   .ROM_INIT(64'hFFFF_FFFF_3A04_FE03)) u_b (
      .XCLK(clk), .RST(rst[1]), .rerun(rerun[1]), .sccb_done(done_in[1]),
      .sccb_start(start_v[1]), .sccb_rw(rw_v[1]), .addr_id(id_v[1]), .addr_reg(areg_v[1]),
      .data_out(dout_v[1]), .init_busy(busy_v[1]), .init_done(idone_v[1]), .init_err(err_v[1]),
      .entry_idx(idx_v[1]));

   sccb_init_seq #(.PWR_WAIT_CYCLES(4), .DELAY_UNIT_CYCLES(5), .TIMEOUT_CYCLES(20), .ROM_DEPTH(4),
                   .ROM_INIT(64'hFFFF_FFFF_1101_1280)) u_c (
      .XCLK(clk), .RST(rst[2]), .rerun(rerun[2]), .sccb_done(done_in[2]),
      .sccb_start(start_v[2]), .sccb_rw(rw_v[2]), .addr_id(id_v[2]), .addr_reg(areg_v[2]),
      .data_out(dout_v[2]), .init_busy(busy_v[2]), .init_done(idone_v[2]), .init_err(err_v[2]),
      .entry_idx(idx_v[2]));

   sccb_init_seq #(.PWR_WAIT_CYCLES(4), .DELAY_UNIT_CYCLES(5), .TIMEOUT_CYCLES(40), .ROM_DEPTH(4),
                   .ROM_INIT(64'h4004_3003_2002_1001)) u_d (
      .XCLK(clk), .RST(rst[3]), .rerun(rerun[3]), .sccb_done(done_in[3]),
      .sccb_start(start_v[3]), .sccb_rw(rw_v[3]), .addr_id(id_v[3]), .addr_reg(areg_v[3]),
      .data_out(dout_v[3]), .init_busy(busy_v[3]), .init_done(idone_v[3]), .init_err(err_v[3]),
      .entry_idx(idx_v[3]));

   int          cyc = 0;
   int          start_count [4] = '{default: 0};
   int          start_cyc   [4][16];
   logic [15:0] wr_log      [4][16];
   int          ack_cnt     [4] = '{default: 0};
   int          err_cyc = -1;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          rel, r;

   always @(posedge clk) cyc <= cyc + 1;

   // Controller model and write logger; the controller shares each instance's reset.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         model_done[i] = 1'b0;
         if (rst[i]) ack_cnt[i] = 0;
         else if (ack_cnt[i] > 0) begin
            ack_cnt[i] = ack_cnt[i] - 1;
            if (ack_cnt[i] == 0) model_done[i] = 1'b1;
         end else if (start_v[i] && ack_en[i]) ack_cnt[i] = ACK_DLY;
         if (start_v[i] && start_count[i] < 16) begin
            wr_log[i][start_count[i]]    = {areg_v[i], dout_v[i]};
            start_cyc[i][start_count[i]] = cyc;
            start_count[i]++;
         end
      end
      if (err_v[2] && err_cyc < 0) err_cyc = cyc;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_start(input int i, input int n, input int budget, input string tag);
      int k = 0;
      while (start_count[i] < n && k < budget) begin
         step();
         k++;
      end
      check(tag, 32'(start_count[i] >= n), 32'd1);
   endtask

   task automatic wait_done(input int i, input int budget, input string tag);
      int k = 0;
      while (!idone_v[i] && k < budget) begin
         step();
         k++;
      end
      check(tag, 32'(idone_v[i]), 32'd1);
   endtask

   initial begin
      repeat (3) step();
      check("rst_start", 32'(start_v[0]), 32'd0);
      check("rst_rw",    32'(rw_v[0]),    32'd0);
      check("rst_id",    32'(id_v[0]),    32'h42);
      check("rst_reg",   32'(areg_v[0]),  32'h0);
      check("rst_data",  32'(dout_v[0]),  32'h0);
      check("rst_busy",  32'(busy_v[0]),  32'd1);
      check("rst_done",  32'(idone_v[0]), 32'd0);
      check("rst_err",   32'(err_v[0]),   32'd0);
      check("rst_idx",   32'(idx_v[0]),   32'd0);

      rst = 4'h0;
      rel = cyc;
      step();
      stray[0] = 1'b1;
      step();
      stray[0] = 1'b0;
      repeat (4) step();
      check("a_stray_no_start", 32'(start_count[0]), 32'd0);
      wait_start(0, 1, 10, "a_first_start_seen");
      check("a_first_start_lat", 32'(start_cyc[0][0] - rel), 32'd7);
      repeat (3) step();
      rerun[0] = 1'b1;
      step();
      rerun[0] = 1'b0;

      wait_done(0, 100, "a_done_seen");
      check("a_busy",   32'(busy_v[0]),      32'd0);
      check("a_err",    32'(err_v[0]),       32'd0);
      check("a_idx",    32'(idx_v[0]),       32'd2);
      check("a_writes", 32'(start_count[0]), 32'd2);
      check("a_wr0",    32'(wr_log[0][0]),   32'h1280);
      check("a_wr1",    32'(wr_log[0][1]),   32'h1101);
      check("a_gap_ge15", 32'((start_cyc[0][1] - start_cyc[0][0]) >= 15), 32'd1);

      wait_done(1, 100, "b_done_seen");
      check("b_writes", 32'(start_count[1]), 32'd1);
      check("b_wr0",    32'(wr_log[1][0]),   32'h3A04);
      check("b_idx",    32'(idx_v[1]),       32'd2);
      check("b_delay_ge15", 32'((start_cyc[1][0] - start_cyc[0][0]) >= 15), 32'd1);

      begin
         int k = 0;
         while (!err_v[2] && k < 100) begin
            step();
            k++;
         end
      end
      check("c_err",     32'(err_v[2]),       32'd1);
      check("c_done",    32'(idone_v[2]),     32'd0);
      check("c_busy",    32'(busy_v[2]),      32'd0);
      check("c_writes",  32'(start_count[2]), 32'd1);
      check("c_to_lat",  32'(err_cyc - start_cyc[2][0]), 32'd20);

      rerun[2] = 1'b1;
      r = cyc;
      step();
      rerun[2] = 1'b0;
      check("c_rerun_err_clr", 32'(err_v[2]),  32'd0);
      check("c_rerun_busy",    32'(busy_v[2]), 32'd1);
      wait_start(2, 2, 10, "c_rerun_start_seen");
      check("c_rerun_lat", 32'(start_cyc[2][1] - r), 32'd4);
      check("c_rerun_wr",  32'(wr_log[2][1]),        32'h1280);

      rerun[0] = 1'b1;
      r = cyc;
      step();
      rerun[0] = 1'b0;
      wait_start(0, 3, 10, "a_rerun_start_seen");
      check("a_rerun_lat", 32'(start_cyc[0][2] - r), 32'd4);
      check("a_rerun_wr",  32'(wr_log[0][2]),        32'h1280);
      wait_start(0, 4, 40, "a_rerun_second_seen");
      repeat (2) step();
      check("a_pre_rst_reg", 32'(areg_v[0]), 32'h11);
      check("a_pre_rst_idx", 32'(idx_v[0]),  32'd1);
      #1 rst[0] = 1'b1;
      #1;
      check("a_mid_rst_start", 32'(start_v[0]), 32'd0);
      check("a_mid_rst_reg",   32'(areg_v[0]),  32'h0);
      check("a_mid_rst_data",  32'(dout_v[0]),  32'h0);
      check("a_mid_rst_idx",   32'(idx_v[0]),   32'd0);
      check("a_mid_rst_busy",  32'(busy_v[0]),  32'd1);
      check("a_mid_rst_done",  32'(idone_v[0]), 32'd0);
      step();
      step();
      rst[0] = 1'b0;
      rel = cyc;
      wait_start(0, 5, 20, "a_restart_start_seen");
      check("a_restart_lat", 32'(start_cyc[0][4] - rel), 32'd7);
      check("a_restart_wr",  32'(wr_log[0][4]),          32'h1280);
      wait_done(0, 100, "a_restart_done_seen");
      check("a_restart_idx",    32'(idx_v[0]),       32'd2);
      check("a_restart_writes", 32'(start_count[0]), 32'd6);
      check("a_restart_wr_last", 32'(wr_log[0][5]),  32'h1101);

      wait_done(3, 200, "d_done_seen");
      check("d_writes", 32'(start_count[3]), 32'd4);
      check("d_idx",    32'(idx_v[3]),       32'd3);
      check("d_wr0",    32'(wr_log[3][0]),   32'h1001);
      check("d_wr3",    32'(wr_log[3][3]),   32'h4004);
      check("d_err",    32'(err_v[3]),       32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
